block_sync_ctrl: RTL and testbench

Lock-sequencing controller for the hierarchical 64b/66b header seeker tree, one per Aurora lane.
- Qualifies the seeker's raw is_synced/offset_pos stream through a hunt -> verify -> locked state machine.
- Tolerates sporadic header errors while locked.
- Restarts the seeker with a reset pulse on timeout or loss of lock.
- Downstream descrambler/framer uses only lock_o and lock_offset_o, never the raw seeker outputs.

---
 rtl/sync_ctrl_pkg.sv | 21 ++
 rtl/sync_err_window.sv | 61 ++++++
 rtl/block_sync_ctrl.sv | 168 ++++++++++++++++
 tb/tb_block_sync_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_ctrl_pkg.sv
// Shared types and default constants for the 64b/66b lock-sequencing controller.
package sync_ctrl_pkg;

   localparam int OFFSET_W = 7;

   localparam int unsigned DEF_LOCK_CNT     = 16;
   localparam int unsigned DEF_HUNT_TIMEOUT = 1024;
   localparam int unsigned DEF_ERR_WIN      = 64;
   localparam int unsigned DEF_MAX_ERR      = 16;
   localparam int unsigned DEF_SEEK_RST_CYC = 4;

   // Encoding is visible on state_o for ILA debug, so values are fixed.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HUNT   = 3'd1,
      ST_VERIFY = 3'd2,
      ST_LOCKED = 3'd3,
      ST_RESEEK = 3'd4
   } state_e;

endpackage

// File: rtl/sync_err_window.sv
// Locked-state error monitor: counts bad samples inside fixed-length windows
// and pulses loss_o on the sample that brings the error count to MAX_ERR.
module sync_err_window
   import sync_ctrl_pkg::*;
#(
   parameter int unsigned ERR_WIN = DEF_ERR_WIN,
   parameter int unsigned MAX_ERR = DEF_MAX_ERR
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sample_i,
   input  logic bad_i,
   input  logic clear_i,
   output logic loss_o
);

   localparam int WCNT_W = $clog2(ERR_WIN + 1);
   localparam int ECNT_W = $clog2(MAX_ERR + 1);

   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [ECNT_W-1:0] ecnt_q, ecnt_d;
   logic              win_end;

   // Loss takes priority over the window wrap when both land on one sample.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      wcnt_d  = wcnt_q;
      ecnt_d  = ecnt_q;
      loss_o  = 1'b0;
      win_end = (wcnt_q == WCNT_W'(ERR_WIN - 1));
      if (clear_i) begin
         wcnt_d = '0;
         ecnt_d = '0;
      end else if (sample_i) begin
         if (bad_i && (ecnt_q == ECNT_W'(MAX_ERR - 1))) begin
            loss_o = 1'b1;
            wcnt_d = '0;
            ecnt_d = '0;
         end else if (win_end) begin
            wcnt_d = '0;
            ecnt_d = '0;
         end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
            ecnt_d = bad_i ? ecnt_q + ECNT_W'(1) : ecnt_q;
         end
      end
   end

   // Window and error counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wcnt_q <= '0;
         ecnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         wcnt_q <= wcnt_d;
         ecnt_q <= ecnt_d;
      end
   end

endmodule

// File: rtl/block_sync_ctrl.sv
// Per-lane lock sequencer: qualifies the raw seeker sync/offset stream through
// hunt -> verify -> locked, and re-seeks the seeker on timeout or loss of lock.
module block_sync_ctrl
   import sync_ctrl_pkg::*;
#(
   parameter int unsigned LOCK_CNT     = DEF_LOCK_CNT,
   parameter int unsigned HUNT_TIMEOUT = DEF_HUNT_TIMEOUT,
   parameter int unsigned ERR_WIN      = DEF_ERR_WIN,
   parameter int unsigned MAX_ERR      = DEF_MAX_ERR,
   parameter int unsigned SEEK_RST_CYC = DEF_SEEK_RST_CYC
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic                buffer_dv,
   input  logic                seek_synced_i,
   input  logic [OFFSET_W-1:0] seek_offset_i,
   output logic                seeker_rst_o,
   output logic                lock_o,
   output logic [OFFSET_W-1:0] lock_offset_o,
   output logic [2:0]          state_o,
   output logic [7:0]          loss_cnt_o
);

   localparam int TCNT_W = $clog2(HUNT_TIMEOUT + 1);
   localparam int VCNT_W = $clog2(LOCK_CNT + 1);
   localparam int RCNT_W = $clog2(SEEK_RST_CYC + 1);

   state_e              state_q, state_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
   logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
   logic [OFFSET_W-1:0] cand_q, cand_d;
   logic [OFFSET_W-1:0] lock_offset_q, lock_offset_d;
   logic [7:0]          loss_cnt_q, loss_cnt_d;
   logic                lock_q, lock_d;
   logic                seeker_rst_q, seeker_rst_d;

   logic win_sample, win_bad, win_clear, win_loss;
   logic sample_ok;

   assign sample_ok  = seek_synced_i && (seek_offset_i == cand_q);
   assign win_sample = en_i && buffer_dv && (state_q == ST_LOCKED);
   assign win_bad    = !(seek_synced_i && (seek_offset_i == lock_offset_q));
   assign win_clear  = !en_i || (state_q != ST_LOCKED);

   sync_err_window #(
      .ERR_WIN (ERR_WIN),
      .MAX_ERR (MAX_ERR)
   ) u_err_window (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .sample_i (win_sample),
      .bad_i    (win_bad),
      .clear_i  (win_clear),
      .loss_o   (win_loss)
   );

   // Next-state, counter and registered-output logic; en_i low overrides all.
   always_comb begin
      state_d       = state_q;
      tcnt_d        = tcnt_q;
      vcnt_d        = vcnt_q;
      rcnt_d        = rcnt_q;
      cand_d        = cand_q;
      lock_offset_d = lock_offset_q;
      loss_cnt_d    = loss_cnt_q;

      if (!en_i) begin
         state_d = ST_IDLE;
         tcnt_d  = '0;
         vcnt_d  = '0;
         rcnt_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_HUNT;

            ST_HUNT: if (buffer_dv) begin
               if (seek_synced_i) begin
                  cand_d  = seek_offset_i;
                  vcnt_d  = VCNT_W'(1);
                  tcnt_d  = '0;
                  state_d = ST_VERIFY;
               end else if (tcnt_q == TCNT_W'(HUNT_TIMEOUT - 1)) begin
                  tcnt_d  = '0;
                  rcnt_d  = '0;
                  state_d = ST_RESEEK;
               end else begin
                  tcnt_d = tcnt_q + TCNT_W'(1);
               end
            end

            ST_VERIFY: if (buffer_dv) begin
               if (sample_ok) begin
                  if (vcnt_q == VCNT_W'(LOCK_CNT - 1)) begin
                     vcnt_d        = '0;
                     lock_offset_d = cand_q;
                     state_d       = ST_LOCKED;
                  end else begin
                     vcnt_d = vcnt_q + VCNT_W'(1);
                  end
               end else if (seek_synced_i) begin
                  cand_d = seek_offset_i;
                  vcnt_d = VCNT_W'(1);
               end else begin
                  vcnt_d  = '0;
                  tcnt_d  = '0;
                  state_d = ST_HUNT;
               end
            end

            ST_LOCKED: if (win_loss) begin
               rcnt_d  = '0;
               state_d = ST_RESEEK;
               if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
            end

            ST_RESEEK: begin
               if (rcnt_q == RCNT_W'(SEEK_RST_CYC - 1)) begin
                  rcnt_d  = '0;
                  tcnt_d  = '0;
                  vcnt_d  = '0;
                  state_d = ST_HUNT;
               end else begin
                  rcnt_d = rcnt_q + RCNT_W'(1);
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end

      lock_d       = (state_d == ST_LOCKED);
      seeker_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESEEK);
   end

   // State, counter and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         tcnt_q        <= '0;
         vcnt_q        <= '0;
         rcnt_q        <= '0;
         cand_q        <= '0;
         lock_offset_q <= '0;
         loss_cnt_q    <= '0;
         lock_q        <= 1'b0;
         seeker_rst_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         tcnt_q        <= tcnt_d;
         vcnt_q        <= vcnt_d;
         rcnt_q        <= rcnt_d;
         cand_q        <= cand_d;
         lock_offset_q <= lock_offset_d;
         loss_cnt_q    <= loss_cnt_d;
         lock_q        <= lock_d;
         seeker_rst_q  <= seeker_rst_d;
      end
   end

   assign seeker_rst_o  = seeker_rst_q;
   assign lock_o        = lock_q;
   assign lock_offset_o = lock_offset_q;
   assign state_o       = state_q;
   assign loss_cnt_o    = loss_cnt_q;

endmodule

// File: tb/tb_block_sync_ctrl.sv
// Self-checking bench for block_sync_ctrl: behavioural model compared every
// cycle, directed scenarios with literal expectations, and randomized traffic.
module tb_block_sync_ctrl;

   localparam int S_IDLE = 0, S_HUNT = 1, S_VERIFY = 2, S_LOCKED = 3, S_RESEEK = 4;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       en_i = 1'b0;
   logic       buffer_dv = 1'b0;
   logic       seek_synced_i = 1'b0;
   logic [6:0] seek_offset_i = '0;
   logic       seeker_rst_o;
   logic       lock_o;
   logic [6:0] lock_offset_o;
   logic [2:0] state_o;
   logic [7:0] loss_cnt_o;

   int checks = 0;
   int failures = 0;

   block_sync_ctrl dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .en_i          (en_i),
      .buffer_dv     (buffer_dv),
      .seek_synced_i (seek_synced_i),
      .seek_offset_i (seek_offset_i),
      .seeker_rst_o  (seeker_rst_o),
      .lock_o        (lock_o),
      .lock_offset_o (lock_offset_o),
      .state_o       (state_o),
      .loss_cnt_o    (loss_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_st = S_IDLE;
   int m_loff = 0, m_loss = 0, m_cand = 0;
   int m_hunt_misses = 0, m_good_run = 0, m_win_samples = 0, m_win_errs = 0, m_reseek_clks = 0;

   function automatic void model_clear_counts();
      m_hunt_misses = 0; m_good_run = 0; m_win_samples = 0; m_win_errs = 0; m_reseek_clks = 0;
   endfunction

   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         m_st = S_IDLE; m_loff = 0; m_loss = 0; m_cand = 0;
         model_clear_counts();
      end else if (!en_i) begin
         m_st = S_IDLE;
         model_clear_counts();
      end else begin
         case (m_st)
            S_IDLE: m_st = S_HUNT;
            S_HUNT: if (buffer_dv) begin
               if (seek_synced_i) begin
                  m_cand = seek_offset_i; m_good_run = 1; m_hunt_misses = 0; m_st = S_VERIFY;
               end else begin
                  m_hunt_misses++;
                  if (m_hunt_misses == 1024) begin
                     m_hunt_misses = 0; m_reseek_clks = 0; m_st = S_RESEEK;
                  end
               end
            end
            S_VERIFY: if (buffer_dv) begin
               if (seek_synced_i && seek_offset_i == m_cand) begin
                  m_good_run++;
                  if (m_good_run == 16) begin
                     m_loff = m_cand; m_good_run = 0; m_win_samples = 0; m_win_errs = 0;
                     m_st = S_LOCKED;
                  end
               end else if (seek_synced_i) begin
                  m_cand = seek_offset_i; m_good_run = 1;
               end else begin
                  m_good_run = 0; m_hunt_misses = 0; m_st = S_HUNT;
               end
            end
            S_LOCKED: if (buffer_dv) begin
               m_win_samples++;
               if (!(seek_synced_i && seek_offset_i == m_loff)) m_win_errs++;
               if (m_win_errs == 16) begin
                  m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                  m_win_samples = 0; m_win_errs = 0; m_reseek_clks = 0; m_st = S_RESEEK;
               end else if (m_win_samples == 64) begin
                  m_win_samples = 0; m_win_errs = 0;
               end
            end
            S_RESEEK: begin
               m_reseek_clks++;
               if (m_reseek_clks == 4) begin
                  model_clear_counts(); m_st = S_HUNT;
               end
            end
            default: m_st = S_IDLE;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("state", int'(state_o), m_st);
      check("lock", int'(lock_o), int'(m_st == S_LOCKED));
      check("seeker_rst", int'(seeker_rst_o), int'(m_st == S_IDLE || m_st == S_RESEEK));
      check("lock_offset", int'(lock_offset_o), m_loff);
      check("loss_cnt", int'(loss_cnt_o), m_loss);
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic dv, input logic syn, input logic [6:0] off);
      buffer_dv = dv; seek_synced_i = syn; seek_offset_i = off;
      @(posedge clk); #3;
   endtask

   task automatic restart(input logic dv, input logic syn, input logic [6:0] off);
      en_i = 1'b0; step(dv, syn, off);
      en_i = 1'b1; step(dv, syn, off);
   endtask

   initial begin
      // Reset with stimulus already parked: en=1, always-valid, synced at 23.
      en_i = 1'b1; buffer_dv = 1'b1; seek_synced_i = 1'b1; seek_offset_i = 7'd23;
      repeat (3) @(posedge clk);
      #3;
      check("rst_state", int'(state_o), S_IDLE);
      check("rst_seeker_rst", int'(seeker_rst_o), 1);
      check("rst_lock", int'(lock_o), 0);
      check("rst_loss", int'(loss_cnt_o), 0);
      check("rst_offset", int'(lock_offset_o), 0);
      rst_ni = 1'b1;

      // Basic lock at 23.
      step(1, 1, 23);
      check("idle_exit_state", int'(state_o), S_HUNT);
      check("idle_exit_seeker_rst", int'(seeker_rst_o), 0);
      repeat (15) step(1, 1, 23);
      check("pre_lock", int'(lock_o), 0);
      step(1, 1, 23);
      check("lock_16th", int'(lock_o), 1);
      check("lock_off23", int'(lock_offset_o), 23);
      check("lock_state", int'(state_o), S_LOCKED);

      // Candidate switch: 23 x5 then 40 x16.
      restart(1, 1, 23);
      repeat (5) step(1, 1, 23);
      check("verify_23", int'(state_o), S_VERIFY);
      for (int i = 0; i < 15; i++) begin
         step(1, 1, 40);
         check("switch_no_lock", int'(lock_o), 0);
      end
      step(1, 1, 40);
      check("switch_lock", int'(lock_o), 1);
      check("switch_off40", int'(lock_offset_o), 40);

      // Hunt timeout with no sync at all.
      restart(1, 0, 0);
      repeat (1023) step(1, 0, 0);
      check("timeout_1023", int'(state_o), S_HUNT);
      step(1, 0, 0);
      check("timeout_1024", int'(state_o), S_RESEEK);
      repeat (3) step(1, 0, 0);
      check("reseek_3clk", int'(seeker_rst_o), 1);
      step(1, 0, 0);
      check("reseek_done", int'(state_o), S_HUNT);
      repeat (1023) step(1, 0, 0);
      check("timeout2_1023", int'(state_o), S_HUNT);
      step(1, 0, 0);
      check("timeout2_1024", int'(state_o), S_RESEEK);
      check("timeout_no_loss", int'(loss_cnt_o), 0);
      repeat (4) step(1, 0, 0);

      // Error window with buffer_dv duty 1/3.
      restart(1, 1, 23);
      repeat (16) step(1, 1, 23);
      check("win_locked", int'(lock_o), 1);
      for (int i = 0; i < 64; i++) begin
         step(1, 1, (i < 15) ? 7'd5 : 7'd23);
         step(0, 1, 5);
         step(0, 1, 5);
      end
      check("win15_lock", int'(lock_o), 1);
      check("win15_state", int'(state_o), S_LOCKED);
      for (int i = 0; i < 16; i++) begin
         step(1, 1, 5);
         if (i < 15) begin
            check("win16_still", int'(lock_o), 1);
            step(0, 1, 5);
            step(0, 1, 5);
         end
      end
      check("loss_lock", int'(lock_o), 0);
      check("loss_cnt1", int'(loss_cnt_o), 1);
      check("loss_state", int'(state_o), S_RESEEK);
      check("loss_seeker_rst", int'(seeker_rst_o), 1);
      repeat (3) step(0, 1, 5);
      check("loss_rs3", int'(seeker_rst_o), 1);
      step(0, 1, 5);
      check("loss_rs4_state", int'(state_o), S_HUNT);
      check("loss_rs4_seeker_rst", int'(seeker_rst_o), 0);

      // Randomized traffic across several error rates.
      for (int seg = 0; seg < 6; seg++) begin
         int rate;
         rate = (seg % 3 == 0) ? 4 : ((seg % 3 == 1) ? 24 : 200);
         for (int c = 0; c < 600; c++) begin
            en_i = ($urandom_range(0, 999) != 0);
            step($urandom_range(0, 2) != 0, $urandom_range(0, rate - 1) != 0,
                 ($urandom_range(0, rate - 1) == 0) ? 7'($urandom_range(0, 127)) : 7'd23);
         end
      end

      // en_i drop while locked.
      restart(1, 1, 23);
      repeat (16) step(1, 1, 23);
      check("en_locked", int'(lock_o), 1);
      begin
         int saved_loss;
         saved_loss = m_loss;
         en_i = 1'b0;
         step(1, 1, 23);
         check("en_lock", int'(lock_o), 0);
         check("en_state", int'(state_o), S_IDLE);
         check("en_seeker_rst", int'(seeker_rst_o), 1);
         check("en_loss_held", int'(loss_cnt_o), saved_loss);
      end

      // Saturation: 256 forced losses from a clean reset.
      rst_ni = 1'b0; step(1, 1, 23); rst_ni = 1'b1; en_i = 1'b1;
      for (int k = 0; k < 256; k++) begin
         for (int t = 0; t < 200 && !lock_o; t++) step(1, 1, 23);
         check("sat_lock_wait", int'(lock_o), 1);
         for (int t = 0; t < 100 && lock_o; t++) step(1, 1, 99);
         check("sat_drop_wait", int'(lock_o), 0);
         check("sat_loss", int'(loss_cnt_o), (k < 255) ? k + 1 : 255);
      end

      // Async reset mid-VERIFY.
      restart(1, 1, 23);
      repeat (3) step(1, 1, 23);
      check("vr_state", int'(state_o), S_VERIFY);
      #1 rst_ni = 1'b0;
      #1;
      check("ar_lock", int'(lock_o), 0);
      check("ar_state", int'(state_o), S_IDLE);
      check("ar_seeker_rst", int'(seeker_rst_o), 1);
      check("ar_loss", int'(loss_cnt_o), 0);
      repeat (2) @(posedge clk);
      #3 rst_ni = 1'b1;
      repeat (3) step(1, 1, 23);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
